set_assoc_wb_cache: RTL and testbench

- Parameterised set-associative, write-back, write-allocate cache between a CPU-side word port and a burst-capable memory port.
- CPU port is a request/waitrequest handshake with single-cycle hits.
- Misses evict the victim line (burst write-back if dirty), then refill it with a burst read.
- Default configuration: 64 lines of 128 bits, 4-way, 16 sets, 32-bit words.

---
 rtl/set_assoc_wb_cache.sv | 239 +++++++++++++++++++++++
 tb/tb_set_assoc_wb_cache.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_wb_cache.sv
`timescale 1ns/1ps
// set_assoc_wb_cache: set-associative, write-back, write-allocate cache.
// Single-cycle hits on the CPU word port; a miss writes back a dirty
// victim line as a burst, then refills that way with a burst read and
// lets the still-held request hit on the following cycle.
module set_assoc_wb_cache #(
    parameter int CLINE_WIDTH    = 128,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int NLINES         = 64,
    parameter int ASSOC          = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [ADDR_WIDTH-1:0]       cpu_addr,
    input  logic                        cpu_rd,
    input  logic                        cpu_wr,
    input  logic [DATA_WIDTH/8-1:0]     cpu_wr_be,
    input  logic [DATA_WIDTH-1:0]       cpu_wr_data,
    output logic                        cpu_rd_valid,
    output logic [DATA_WIDTH-1:0]       cpu_rd_data,
    output logic                        cpu_waitrequest,
    output logic [ADDR_WIDTH-1:0]       mem_addr_r,
    output logic [1:0]                  mem_burst_len,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_rd_data,
    input  logic                        mem_rd_valid,
    input  logic                        mem_waitrequest,
    output logic [MEM_DATA_WIDTH-1:0]   mem_wr_data_r,
    output logic                        mem_wr_r,
    output logic                        mem_rd_r
);

    localparam int WPL   = CLINE_WIDTH / MEM_DATA_WIDTH;
    localparam int NSETS = NLINES / ASSOC;
    localparam int BEW   = DATA_WIDTH / 8;
    localparam int BOFF  = $clog2(BEW);
    localparam int OFFW  = $clog2(CLINE_WIDTH / 8);
    localparam int IDXW  = $clog2(NSETS);
    localparam int TAGW  = ADDR_WIDTH - OFFW - IDXW;
    localparam int WSW   = $clog2(WPL);
    localparam int WAYW  = $clog2(ASSOC);
    localparam logic [WSW-1:0] LAST_BEAT = WSW'(WPL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_REFILL_REQ,
        S_REFILL
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  data_q  [NSETS][ASSOC][WPL];
    logic [TAGW-1:0]        tag_q   [NSETS][ASSOC];
    logic                   valid_q [NSETS][ASSOC];
    logic                   dirty_q [NSETS][ASSOC];
    // Age 0 = most recently used; the oldest way is the LRU victim.
    logic [WAYW-1:0]        age_q   [NSETS][ASSOC];

    logic [IDXW-1:0]        miss_idx_q;
    logic [TAGW-1:0]        miss_tag_q;
    logic [WAYW-1:0]        miss_way_q;
    logic [WSW-1:0]         beat_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;

    logic [IDXW-1:0]        req_idx;
    logic [TAGW-1:0]        req_tag;
    logic [WSW-1:0]         req_wsel;
    logic [WSW-1:0]         beat_nxt;
    logic                   req_active;
    logic                   hit;
    logic [WAYW-1:0]        hit_way;
    logic                   found_inv;
    logic [WAYW-1:0]        victim_way;
    logic [WAYW-1:0]        best_age;
    logic                   victim_dirty;
    logic                   acc;
    logic                   rd_acc;
    logic                   wr_acc;
    logic [DATA_WIDTH-1:0]  hit_word;
    logic [DATA_WIDTH-1:0]  merged_word;
    logic                   addr_lsb_unused;

    assign req_idx         = cpu_addr[OFFW +: IDXW];
    assign req_tag         = cpu_addr[ADDR_WIDTH-1 -: TAGW];
    assign req_wsel        = cpu_addr[BOFF +: WSW];
    assign addr_lsb_unused = ^cpu_addr[BOFF-1:0];
    assign beat_nxt        = beat_q + WSW'(1);

    // Only IDLE serves the CPU; reset blocks acceptance outright.
    assign req_active = (cpu_rd | cpu_wr) & (state_q == S_IDLE) & ~reset;
    assign acc        = req_active & hit;
    assign wr_acc     = acc & cpu_wr;
    assign rd_acc     = acc & ~cpu_wr;

    assign hit_word        = data_q[req_idx][hit_way][req_wsel];
    assign cpu_waitrequest = ~acc;
    assign cpu_rd_valid    = rd_acc;
    assign cpu_rd_data     = rd_acc ? hit_word : rd_data_q;
    assign mem_burst_len   = 2'(WPL - 1);
    assign victim_dirty    = valid_q[req_idx][victim_way] & dirty_q[req_idx][victim_way];

    // Tag compare and victim choice: first invalid way, else the oldest.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_inv  = 1'b0;
        victim_way = '0;
        best_age   = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAYW'(w);
            end
        end
        for (int w = 0; w < ASSOC; w++) begin
            if (!found_inv && !valid_q[req_idx][w]) begin
                found_inv  = 1'b1;
                victim_way = WAYW'(w);
            end
        end
        if (!found_inv) begin
            best_age = age_q[req_idx][0];
            for (int w = 1; w < ASSOC; w++) begin
                if (age_q[req_idx][w] > best_age) begin
                    best_age   = age_q[req_idx][w];
                    victim_way = WAYW'(w);
                end
            end
        end
    end

    // Byte-merge of write data into the currently stored word.
    always_comb begin
        merged_word = hit_word;
        for (int b = 0; b < BEW; b++) begin
            if (cpu_wr_be[b]) merged_word[b*8 +: 8] = cpu_wr_data[b*8 +: 8];
        end
    end

    // Line storage (data and tags) is not reset; valid bits guard it.
    always_ff @(posedge clock) begin
        if (wr_acc) data_q[req_idx][hit_way][req_wsel] <= merged_word;
        if (!reset && (state_q == S_REFILL) && mem_rd_valid) begin
            data_q[miss_idx_q][miss_way_q][beat_q] <= mem_rd_data;
            if (beat_q == LAST_BEAT) tag_q[miss_idx_q][miss_way_q] <= miss_tag_q;
        end
    end

    // Miss-handling FSM with line state, LRU ages and registered memory outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            mem_rd_r      <= 1'b0;
            mem_wr_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_data_r <= '0;
            rd_data_q     <= '0;
            beat_q        <= '0;
            miss_idx_q    <= '0;
            miss_tag_q    <= '0;
            miss_way_q    <= '0;
            for (int s = 0; s < NSETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (acc) begin
                        // Ways younger than or tied with the hit way age by one.
                        for (int w = 0; w < ASSOC; w++) begin
                            if (WAYW'(w) == hit_way) begin
                                age_q[req_idx][w] <= '0;
                            end else if ((age_q[req_idx][w] <= age_q[req_idx][hit_way]) &&
                                         (age_q[req_idx][w] != '1)) begin
                                age_q[req_idx][w] <= age_q[req_idx][w] + WAYW'(1);
                            end
                        end
                        if (wr_acc) dirty_q[req_idx][hit_way] <= 1'b1;
                        if (rd_acc) rd_data_q <= hit_word;
                    end else if (req_active) begin
                        miss_idx_q <= req_idx;
                        miss_tag_q <= req_tag;
                        miss_way_q <= victim_way;
                        beat_q     <= '0;
                        if (victim_dirty) begin
                            state_q       <= S_WRITEBACK;
                            mem_wr_r      <= 1'b1;
                            mem_addr_r    <= {tag_q[req_idx][victim_way], req_idx, {OFFW{1'b0}}};
                            mem_wr_data_r <= data_q[req_idx][victim_way][0];
                        end else begin
                            state_q    <= S_REFILL_REQ;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {req_tag, req_idx, {OFFW{1'b0}}};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!mem_waitrequest) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q    <= S_REFILL_REQ;
                            beat_q     <= '0;
                            mem_wr_r   <= 1'b0;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {miss_tag_q, miss_idx_q, {OFFW{1'b0}}};
                        end else begin
                            beat_q        <= beat_nxt;
                            mem_wr_data_r <= data_q[miss_idx_q][miss_way_q][beat_nxt];
                        end
                    end
                end
                S_REFILL_REQ: begin
                    if (!mem_waitrequest) begin
                        state_q  <= S_REFILL;
                        mem_rd_r <= 1'b0;
                    end
                end
                S_REFILL: begin
                    if (mem_rd_valid) begin
                        if (beat_q == LAST_BEAT) begin
                            state_q                         <= S_IDLE;
                            beat_q                          <= '0;
                            valid_q[miss_idx_q][miss_way_q] <= 1'b1;
                            dirty_q[miss_idx_q][miss_way_q] <= 1'b0;
                        end else begin
                            beat_q <= beat_nxt;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
`timescale 1ns/1ps
// Directed bench for set_assoc_wb_cache with a burst memory model
// (word k holds k) and a read-data scoreboard.
module tb_set_assoc_wb_cache;

    logic        clock;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [3:0]  cpu_wr_be;
    logic [31:0] cpu_wr_data;
    logic        cpu_rd_valid;
    logic [31:0] cpu_rd_data;
    logic        cpu_waitrequest;
    logic [31:0] mem_addr_r;
    logic [1:0]  mem_burst_len;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_waitrequest;
    logic [31:0] mem_wr_data_r;
    logic        mem_wr_r;
    logic        mem_rd_r;

    set_assoc_wb_cache dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_addr        (cpu_addr),
        .cpu_rd          (cpu_rd),
        .cpu_wr          (cpu_wr),
        .cpu_wr_be       (cpu_wr_be),
        .cpu_wr_data     (cpu_wr_data),
        .cpu_rd_valid    (cpu_rd_valid),
        .cpu_rd_data     (cpu_rd_data),
        .cpu_waitrequest (cpu_waitrequest),
        .mem_addr_r      (mem_addr_r),
        .mem_burst_len   (mem_burst_len),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_valid    (mem_rd_valid),
        .mem_waitrequest (mem_waitrequest),
        .mem_wr_data_r   (mem_wr_data_r),
        .mem_wr_r        (mem_wr_r),
        .mem_rd_r        (mem_rd_r)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [16384];
    bit          mem_init_done = 1'b0;
    bit          hold_wait = 1'b0;
    int          cyc = 0;
    int          rd_st = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_base = '0;
    int          wr_cnt = 0;
    int          rd_bursts = 0;
    int          wr_bursts = 0;
    logic [31:0] last_rd_addr = '0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] wb_data [4];

    // Memory responder works on the falling edge so its outputs are
    // stable at the DUT's rising edge.
    always @(negedge clock) begin
        if (!mem_init_done) begin
            for (int k = 0; k < 16384; k++) mem[k] = k;
            mem_init_done = 1'b1;
        end
        cyc++;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        mem_waitrequest = hold_wait || (cyc % 5 == 3);
        if (reset) begin
            rd_st  = 0;
            wr_cnt = 0;
        end else begin
            if (mem_wr_r && !mem_waitrequest) begin
                if (wr_cnt == 0) begin
                    wr_bursts++;
                    last_wr_addr = mem_addr_r;
                end
                mem[(int'(mem_addr_r >> 2) + wr_cnt) & 16383] = mem_wr_data_r;
                wb_data[wr_cnt] = mem_wr_data_r;
                wr_cnt = (wr_cnt + 1) % 4;
            end
            if (rd_st == 2) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[(int'(rd_base >> 2) + rd_cnt) & 16383];
                rd_cnt++;
                if (rd_cnt == 4) rd_st = 0;
            end else if (rd_st == 1) begin
                rd_st = 2;
            end else if (mem_rd_r && !mem_waitrequest) begin
                rd_st        = 1;
                rd_cnt       = 0;
                rd_base      = mem_addr_r;
                last_rd_addr = mem_addr_r;
                rd_bursts++;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (!reset && cpu_rd && !cpu_wr && cpu_rd_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got data 0x%08h, expected no read completion", cpu_rd_data);
            end else begin
                check("rd_data", cpu_rd_data, exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat);
        @(posedge clock);
        #1;
        cpu_addr    = addr;
        cpu_rd      = !wr;
        cpu_wr      = wr;
        cpu_wr_data = wdata;
        cpu_wr_be   = be;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (cpu_waitrequest && lat < 300);
        if (cpu_waitrequest) begin
            n_total++;
            $display("FAIL req_timeout: addr 0x%08h still stalled after %0d cycles, expected acceptance", addr, lat);
        end
        @(posedge clock);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, output int lat);
        exp_q.push_back(exp);
        do_req(1'b0, addr, '0, '0, lat);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                      output int lat);
        do_req(1'b1, addr, data, be, lat);
    endtask

    initial begin
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, rb, wbb, misses, misplaced, wb_early, seen;
        reset       = 1'b1;
        cpu_addr    = '0;
        cpu_rd      = 1'b1;
        cpu_wr      = 1'b0;
        cpu_wr_be   = '0;
        cpu_wr_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_waitrequest", cpu_waitrequest, 1);
        check("rst_rd_valid", cpu_rd_valid, 0);
        check("rst_rd_data", cpu_rd_data, 0);
        check("rst_mem_rd", mem_rd_r, 0);
        check("rst_mem_wr", mem_wr_r, 0);
        check("rst_mem_addr", mem_addr_r, 0);
        check("rst_mem_wdata", mem_wr_data_r, 0);
        check("burst_len", mem_burst_len, 3);
        @(posedge clock);
        #1;
        reset  = 1'b0;
        cpu_rd = 1'b0;

        // Cold read miss then hit in the same line
        rb = rd_bursts; wbb = wr_bursts;
        rd(32'h400, 32'h100, lat);
        check("cold_miss_lat", lat > 1, 1);
        check("cold_rd_bursts", rd_bursts - rb, 1);
        check("cold_rd_addr", last_rd_addr, 32'h400);
        check("cold_no_wb", wr_bursts - wbb, 0);
        rd(32'h404, 32'h101, lat);
        check("hit_lat", lat, 1);
        check("hit_no_burst", rd_bursts - rb, 1);

        // Write-allocate and byte merges
        wr(32'h0, 32'h10, 4'b1111, lat);
        check("wr_alloc_lat", lat > 1, 1);
        rd(32'h0, 32'h10, lat);
        check("rd_after_wr_lat", lat, 1);
        wr(32'h0, 32'hFF, 4'b0001, lat);
        check("wr_hit_lat", lat, 1);
        rd(32'h0, 32'hFF, lat);
        wr(32'h0, 32'hAABBCCDD, 4'b0010, lat);
        rd(32'h0, 32'h0000CCFF, lat);

        // Fill set 0: 0x300 evicts clean LRU (0x400), then 0x400 evicts dirty 0x0
        rd(32'h100, 32'h40, lat);
        rd(32'h200, 32'h80, lat);
        wbb = wr_bursts;
        rd(32'h300, 32'hC0, lat);
        check("clean_victim_no_wb", wr_bursts - wbb, 0);
        rd(32'h400, 32'h100, lat);
        check("dirty_wb_bursts", wr_bursts - wbb, 1);
        check("dirty_wb_addr", last_wr_addr, 32'h0);
        check("wb_beat0", wb_data[0], 32'h0000CCFF);
        check("wb_beat1", wb_data[1], 32'h1);
        check("wb_beat3", wb_data[3], 32'h3);
        rd(32'h0, 32'h0000CCFF, lat);
        check("reread_miss_lat", lat > 1, 1);
        check("reread_no_wb", wr_bursts - wbb, 1);

        // Sequential write sweep: 914 words -> 229 lines, 64 fit without dirty evictions
        rb = rd_bursts; wbb = wr_bursts;
        misses = 0; misplaced = 0; wb_early = -1;
        for (int w = 4096; w <= 5009; w++) begin
            wr(w * 4, w ^ 32'h5A000000, 4'b1111, lat);
            if (lat > 1) begin
                misses++;
                if (w % 4 != 0) misplaced++;
            end
            if (w == 4096 + 255) wb_early = wr_bursts - wbb;
        end
        check("sweep_misses", misses, 229);
        check("sweep_miss_pos", misplaced, 0);
        check("sweep_rd_bursts", rd_bursts - rb, 229);
        check("sweep_clean_no_wb", wb_early, 0);
        check("sweep_wb_bursts", wr_bursts - wbb, 165);
        rd(32'h4E40, 32'h5A001390, lat);
        check("sweep_hit_lat", lat, 1);

        // Reset during a stalled write-back
        @(posedge clock);
        #1;
        hold_wait = 1'b1;
        cpu_addr  = 32'h8000;
        cpu_rd    = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clock);
            if (mem_wr_r) seen = 1;
        end
        check("wb_started", seen, 1);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_wb_mem_wr", mem_wr_r, 0);
        check("rst_wb_mem_rd", mem_rd_r, 0);
        @(posedge clock);
        #1;
        reset     = 1'b0;
        hold_wait = 1'b0;

        // Reset mid-refill
        @(posedge clock);
        #1;
        cpu_addr = 32'h8000;
        cpu_rd   = 1'b1;
        seen = 0;
        for (int i = 0; i < 50 && seen == 0; i++) begin
            @(negedge clock);
            if (mem_rd_valid) seen = 1;
        end
        check("refill_started", seen, 1);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_rf_mem_rd", mem_rd_r, 0);
        check("rst_rf_mem_wr", mem_wr_r, 0);
        check("rst_rf_mem_addr", mem_addr_r, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // All lines invalid: dirty data of 0x4E40 was lost, memory still holds 5008
        rb = rd_bursts;
        rd(32'h4E40, 32'h1390, lat);
        check("post_rst_miss_lat", lat > 1, 1);
        rd(32'h8000, 32'h2000, lat);
        check("post_rst_miss2_lat", lat > 1, 1);
        check("post_rst_bursts", rd_bursts - rb, 2);

        repeat (3) @(posedge clock);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
